// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector operand loader and the systolic array.
// Provides the problem size, element type, index type and the loader state encoding.
package mv_pkg;

  localparam int unsigned MATRIX_SIZE = 16;
  localparam int unsigned DATA_W      = 8;
  // Keep the index at least one bit wide so a 1x1 build still elaborates.
  localparam int unsigned IDX_W       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]         idx_t;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StCompute,
    StDone
  } state_e;

endpackage

// File: rtl/mv_index_counter.sv
// Row/column index counter used to address the operand buffers while loading.
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_en            advance one position
//   i_row_en        allow the row to advance when the column wraps
//   i_clr           return both indices to zero
//   o_row, o_col    current indices
//   o_row_last      row is at MATRIX_SIZE-1
//   o_col_last      column is at MATRIX_SIZE-1
module mv_index_counter
  import mv_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_row_en,
  input  logic i_clr,
  output idx_t o_row,
  output idx_t o_col,
  output logic o_row_last,
  output logic o_col_last
);

  localparam idx_t LastIdx = idx_t'(MATRIX_SIZE - 1);

  idx_t r_row;
  idx_t r_col;

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_row_last = (r_row == LastIdx);
  assign o_col_last = (r_col == LastIdx);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (o_col_last) begin
        r_col <= '0;
        // Row wraps explicitly so non-power-of-two sizes behave too.
        if (i_row_en) begin
          r_row <= o_row_last ? '0 : r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mv_operand_loader.sv
// Streams N*N matrix elements (row-major) then N vector elements into the
// systolic array operand buffers, then sequences the array through a fixed
// compute window and a result-valid/ack handshake. Jobs run back-to-back.
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   in_valid/in_ready   element handshake; in_data is the signed element
//   A, B                operand buffers driven to the array
//   arr_reset           active-high array reset (low during compute/done)
//   busy                high while computing or holding a result
//   result_valid        array output is valid; cleared by result_ack
module mv_operand_loader
  import mv_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 46
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  elem_t in_data,
  output elem_t A [MATRIX_SIZE][MATRIX_SIZE],
  output elem_t B [MATRIX_SIZE],
  output logic  arr_reset,
  output logic  busy,
  output logic  result_valid,
  input  logic  result_ack
);

  localparam int unsigned CYC_W = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(COMPUTE_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [CYC_W-1:0] r_cycle;
  logic             r_arr_reset;
  logic             r_result_valid;
  elem_t            r_a [MATRIX_SIZE][MATRIX_SIZE];
  elem_t            r_b [MATRIX_SIZE];

  idx_t w_row;
  idx_t w_col;
  logic w_row_last;
  logic w_col_last;
  logic w_loading;
  logic w_xfer;
  logic w_cnt_clr;

  assign w_loading    = (r_state == StLoadA) || (r_state == StLoadB);
  assign in_ready     = reset && w_loading;
  assign w_xfer       = in_valid && in_ready;
  assign w_cnt_clr    = (r_state == StDone) && result_ack;
  assign busy         = (r_state == StCompute) || (r_state == StDone);
  assign arr_reset    = r_arr_reset;
  assign result_valid = r_result_valid;
  assign A            = r_a;
  assign B            = r_b;

  // One counter serves both load phases; in LOAD_B only the column moves.
  mv_index_counter u_idx (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_en       (w_xfer),
    .i_row_en   (r_state == StLoadA),
    .i_clr      (w_cnt_clr),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_row_last (w_row_last),
    .o_col_last (w_col_last)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLoadA:   if (w_xfer && w_col_last && w_row_last) w_state_d = StLoadB;
      StLoadB:   if (w_xfer && w_col_last) w_state_d = StCompute;
      StCompute: if (r_cycle == CYC_LAST) w_state_d = StDone;
      StDone:    if (result_ack) w_state_d = StLoadA;
      default:   w_state_d = StLoadA;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= StLoadA;
      r_cycle        <= '0;
      r_arr_reset    <= 1'b1;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_arr_reset    <= (w_state_d == StLoadA) || (w_state_d == StLoadB);
      r_result_valid <= (w_state_d == StDone);
      if (r_state == StCompute) begin
        r_cycle <= r_cycle + 1'b1;
      end else begin
        r_cycle <= '0;
      end
    end
  end

  // Buffers are only written on accepted transfers, so they hold steady
  // through compute and done, and keep old values until overwritten.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MATRIX_SIZE; i++) begin
        r_b[i] <= '0;
        for (int unsigned j = 0; j < MATRIX_SIZE; j++) begin
          r_a[i][j] <= '0;
        end
      end
    end else if (w_xfer) begin
      if (r_state == StLoadA) begin
        r_a[w_row][w_col] <= in_data;
      end else begin
        r_b[w_col] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_mv_operand_loader.sv
module tb_mv_operand_loader;
  import mv_pkg::*;

  localparam int unsigned N     = MATRIX_SIZE;
  localparam int unsigned CC    = 46;
  localparam int unsigned TOTAL = N * N + N;

  logic  clk = 1'b0;
  logic  reset;
  logic  in_valid;
  logic  in_ready;
  elem_t in_data;
  elem_t a_w [N][N];
  elem_t b_w [N];
  logic  arr_reset;
  logic  busy;
  logic  result_valid;
  logic  result_ack;

  int checks   = 0;
  int failures = 0;

  // Reference model: buffer contents implied by the accepted stream.
  elem_t m_a [N][N];
  elem_t m_b [N];
  elem_t job_q[$];

  mv_operand_loader #(.COMPUTE_CYCLES(CC)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .A            (a_w),
    .B            (b_w),
    .arr_reset    (arr_reset),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_b[i] = '0;
      for (int j = 0; j < N; j++) m_a[i][j] = '0;
    end
  endtask

  // Stream element k lands at A[k/N][k%N] for the first N*N, then at B[k-N*N].
  task automatic model_write(input int unsigned k, input elem_t v);
    if (k < N * N) m_a[k / N][k % N] = v;
    else           m_b[k - N * N] = v;
  endtask

  task automatic check_ab(input string tag);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s_B[%0d]", tag, i), int'(b_w[i]), int'(m_b[i]));
      for (int j = 0; j < N; j++)
        check_val($sformatf("%s_A[%0d][%0d]", tag, i, j), int'(a_w[i][j]), int'(m_a[i][j]));
    end
  endtask

  function automatic int dut_c(input int i);
    int s = 0;
    for (int j = 0; j < N; j++) s += int'(a_w[i][j]) * int'(b_w[j]);
    return s;
  endfunction

  function automatic int model_c(input int i);
    int s = 0;
    for (int j = 0; j < N; j++) s += int'(m_a[i][j]) * int'(m_b[j]);
    return s;
  endfunction

  task automatic check_c(input string tag);
    for (int i = 0; i < N; i++) check_val($sformatf("%s_C[%0d]", tag, i), dut_c(i), model_c(i));
  endtask

  task automatic fill_random();
    job_q.delete();
    for (int k = 0; k < TOTAL; k++) job_q.push_back(elem_t'($urandom));
  endtask

  task automatic fill_identity();
    job_q.delete();
    for (int k = 0; k < N * N; k++) job_q.push_back((k / N == k % N) ? elem_t'(1) : elem_t'(0));
    for (int k = 0; k < N; k++) job_q.push_back(elem_t'(k + 1));
  endtask

  task automatic fill_const(input elem_t av, input elem_t bv);
    job_q.delete();
    for (int k = 0; k < N * N; k++) job_q.push_back(av);
    for (int k = 0; k < N; k++) job_q.push_back(bv);
  endtask

  // Streams job_q[0..limit-1] with in_valid asserted pct% of cycles.
  task automatic load_job(input int unsigned pct, input logic ack, input int unsigned limit);
    int unsigned idx   = 0;
    int unsigned guard = 0;
    result_ack = ack;
    while (idx < limit && guard < 20000) begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = in_valid ? job_q[idx] : elem_t'($urandom);
      check_bit("load_in_ready", in_ready, 1'b1);
      check_bit("load_arr_reset", arr_reset, 1'b1);
      check_bit("load_busy", busy, 1'b0);
      check_bit("load_result_valid", result_valid, 1'b0);
      @(posedge clk);
      if (in_valid) begin
        model_write(idx, job_q[idx]);
        idx++;
      end
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < limit) check_val("load_timeout", int'(idx), int'(limit));
  endtask

  // Entered #1 after the last B transfer edge; exits #1 after the edge that
  // should raise result_valid. Input traffic here must be ignored.
  task automatic compute_phase(input logic ack);
    result_ack = ack;
    for (int k = 0; k < CC; k++) begin
      in_valid = 1'($urandom_range(1));
      in_data  = elem_t'($urandom);
      check_bit("comp_in_ready", in_ready, 1'b0);
      check_bit("comp_arr_reset", arr_reset, 1'b0);
      check_bit("comp_busy", busy, 1'b1);
      check_bit("comp_result_valid", result_valid, 1'b0);
      step();
    end
    in_valid = 1'b0;
    check_bit("done_result_valid", result_valid, 1'b1);
    check_bit("done_busy", busy, 1'b1);
    check_bit("done_arr_reset", arr_reset, 1'b0);
    check_bit("done_in_ready", in_ready, 1'b0);
  endtask

  task automatic done_phase(input int hold);
    for (int h = 0; h < hold; h++) begin
      result_ack = 1'b0;
      check_bit("hold_result_valid", result_valid, 1'b1);
      check_bit("hold_in_ready", in_ready, 1'b0);
      step();
    end
    result_ack = 1'b1;
    check_bit("pre_ack_result_valid", result_valid, 1'b1);
    step();
    result_ack = 1'b0;
    check_bit("post_ack_result_valid", result_valid, 1'b0);
    check_bit("post_ack_in_ready", in_ready, 1'b1);
    check_bit("post_ack_arr_reset", arr_reset, 1'b1);
    check_bit("post_ack_busy", busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    result_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_in_ready_gated", in_ready, 1'b0);
    check_bit("rst_arr_reset", arr_reset, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_result_valid", result_valid, 1'b0);
    model_clear();
    check_ab("rst");
    reset = 1'b1;
    #1;
    check_bit("rst_release_in_ready", in_ready, 1'b1);

    // Identity matrix at full rate, result held for a few cycles.
    fill_identity();
    load_job(100, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_ab("t1");
    for (int i = 0; i < N; i++) check_val($sformatf("t1_C_%0d", i), dut_c(i), i + 1);
    done_phase(3);

    // Sparse random valid.
    fill_random();
    load_job(30, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_ab("t2");
    check_c("t2");
    done_phase(0);

    // Reset in the middle of LOAD_B discards everything.
    fill_random();
    load_job(100, 1'b0, N * N + 3);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = elem_t'($urandom);
    #1;
    check_bit("t3_in_ready_gated", in_ready, 1'b0);
    step();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    model_clear();
    check_bit("t3_arr_reset", arr_reset, 1'b1);
    check_bit("t3_in_ready", in_ready, 1'b1);
    check_bit("t3_busy", busy, 1'b0);
    check_ab("t3_rst");
    fill_random();
    load_job(70, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_ab("t3");
    check_c("t3");
    done_phase(0);

    // Back-to-back jobs, ack in the first DONE cycle.
    fill_random();
    load_job(100, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_c("t4a");
    done_phase(0);
    fill_const(elem_t'(-1), elem_t'(127));
    load_job(100, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_ab("t4b");
    check_c("t4b");
    done_phase(0);

    // Extreme values stored bit-exact.
    fill_random();
    job_q[0]         = elem_t'(-128);
    job_q[1]         = elem_t'(127);
    job_q[2]         = elem_t'(0);
    job_q[TOTAL - 1] = elem_t'(-128);
    load_job(100, 1'b0, TOTAL);
    compute_phase(1'b0);
    check_ab("t5");
    check_val("t5_A00_bits", int'({24'h0, a_w[0][0]}), 32'h80);
    check_val("t5_A01_bits", int'({24'h0, a_w[0][1]}), 32'h7F);
    check_val("t5_A02_bits", int'({24'h0, a_w[0][2]}), 32'h00);
    check_val("t5_B15_bits", int'({24'h0, b_w[N-1]}), 32'h80);
    done_phase(0);

    // Ack held high throughout loading and computing.
    fill_random();
    load_job(50, 1'b1, TOTAL);
    compute_phase(1'b1);
    check_ab("t6");
    done_phase(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
